// File: rtl/phase_seq_gen_if.sv
// phase_seq_gen_if: control inputs and phase/strobe outputs of the instruction-phase sequencer
interface phase_seq_gen_if #(
  parameter int PH_W  = 3,
  parameter int CNT_W = 16
);
  logic             stall;
  logic             halt_req;
  logic             step;
  logic             fetch;
  logic             alu_ena;
  logic             cycle_start;
  logic [PH_W-1:0]  phase;
  logic             halted;
  logic [CNT_W-1:0] instr_cnt;
  modport master (
    output stall, halt_req, step,
    input  fetch, alu_ena, cycle_start, phase, halted, instr_cnt
  );
  modport slave (
    input  stall, halt_req, step,
    output fetch, alu_ena, cycle_start, phase, halted, instr_cnt
  );
endinterface

// File: rtl/phase_seq_gen.sv
// phase_seq_gen: splits each instruction cycle into NUM_PHASES phases, with stall, halt-at-boundary,
// single-step and a completed-cycle counter; all outputs registered
module phase_seq_gen #(
  parameter int NUM_PHASES  = 8,
  parameter int ALU_PHASE   = 1,
  parameter int FETCH_START = 3,
  parameter int FETCH_END   = 6,
  parameter int CNT_W       = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  phase_seq_gen_if.slave bus
);
  localparam int PH_W = $clog2(NUM_PHASES);
  localparam logic [PH_W-1:0] LAST = PH_W'(NUM_PHASES - 1);
  localparam logic [PH_W-1:0] ALU  = PH_W'(ALU_PHASE);
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t           state, state_nx;
  logic [PH_W-1:0]  phase, phase_nx;
  logic [CNT_W-1:0] cnt;
  logic             hold, wrap;
  logic             fetch_q, alu_q, cs_q, halted_q;
  logic             fetch_d, alu_d, cs_d, halted_d;
  assign hold = state == RUN && bus.stall;
  assign wrap = state == RUN && !bus.stall && phase == LAST;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      phase    <= '0;
      cnt      <= '0;
      fetch_q  <= 1'b0;
      alu_q    <= 1'b0;
      cs_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state    <= state_nx;
      phase    <= phase_nx;
      cnt      <= wrap ? cnt + 1'b1 : cnt;
      fetch_q  <= fetch_d;
      alu_q    <= alu_d;
      cs_q     <= cs_d;
      halted_q <= halted_d;
    end
  end
  // halt_req only matters at the wrap boundary or while already halted
  always_comb begin
    state_nx = state;
    phase_nx = phase;
    case (state)
      IDLE: begin
        state_nx = bus.halt_req ? HALT : RUN;
        phase_nx = '0;
      end
      RUN: begin
        phase_nx = hold ? phase : wrap ? '0 : phase + 1'b1;
        state_nx = wrap && bus.halt_req ? HALT : RUN;
      end
      HALT: begin
        phase_nx = '0;
        state_nx = !bus.halt_req || bus.step ? RUN : HALT;
      end
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
      end
    endcase
  end
  // strobes fire only on the clock a phase is entered, never on a held repeat of it
  always_comb begin
    fetch_d  = state_nx == RUN && int'(phase_nx) >= FETCH_START && int'(phase_nx) <= FETCH_END;
    alu_d    = state_nx == RUN && phase_nx == ALU && !hold;
    cs_d     = state_nx == RUN && phase_nx == '0 && !hold;
    halted_d = state_nx == HALT;
  end
  assign bus.fetch       = fetch_q;
  assign bus.alu_ena     = alu_q;
  assign bus.cycle_start = cs_q;
  assign bus.phase       = phase;
  assign bus.halted      = halted_q;
  assign bus.instr_cnt   = cnt;
endmodule

// File: doc/phase_seq_gen.md
Name: phase_seq_gen

Overview:
- Parametrised instruction-phase sequencer for the multi-cycle RISC core; next generation of the fixed 8-phase clock/phase generator.
- Splits each instruction cycle into NUM_PHASES clock phases and produces the fetch window and ALU enable strobe from configurable phase positions.
- Adds stall, halt-at-boundary, single-step and a completed-cycle counter, so the controller and debug logic can freeze or step the core cleanly.

Parameters:
- NUM_PHASES, 8, phases per instruction cycle; legal range 4..16.
- ALU_PHASE, 1, phase index in which alu_ena is high; must be < NUM_PHASES.
- FETCH_START, 3, first phase index with fetch high.
- FETCH_END, 6, last phase index with fetch high; FETCH_START <= FETCH_END < NUM_PHASES.
- CNT_W, 16, instr_cnt width.
- Local PH_W = clog2(NUM_PHASES).

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- stall  in  1  level; freezes the phase counter while high.
- halt_req  in  1  level; requests halt at the next instruction-cycle boundary.
- step  in  1  one-clock pulse; in HALT, runs exactly one instruction cycle.
- fetch  out  1  high during phases FETCH_START..FETCH_END in RUN.
- alu_ena  out  1  high during phase ALU_PHASE in RUN, unless stalled.
- cycle_start  out  1  one-clock pulse on first clock of phase 0 of each instruction cycle.
- phase  out  PH_W  current phase index.
- halted  out  1  high while in HALT.
- instr_cnt  out  CNT_W  completed instruction cycles, wraps modulo 2^CNT_W.

Behaviour:
- Reset (async assert, sync release): state IDLE, phase=0, instr_cnt=0; fetch, alu_ena, cycle_start, halted all 0.
- All outputs are registered.
- Outputs are a Moore decode of (state, phase, stall) for the current cycle: no combinational path from inputs to outputs, except that alu_ena is registered from the next-state stall decode.
- IDLE:
  - Lasts exactly one clock.
  - Goes to HALT (phase 0) if halt_req=1, else to RUN (phase 0).
- RUN:
  - stall=1: phase holds; fetch holds its decode value; alu_ena forced 0; no count.
  - stall=0 and phase < NUM_PHASES-1: phase increments.
  - stall=0 and phase = NUM_PHASES-1: the boundary. phase returns to 0 and instr_cnt increments.
  - At the boundary, next state is HALT if halt_req=1, else RUN.
- HALT:
  - phase=0; fetch, alu_ena and cycle_start are 0; halted=1.
  - halt_req=0 leaves to RUN at phase 0.
  - step=1 with halt_req=1 also leaves to RUN at phase 0. halt_req is still high at the next boundary, so the block returns to HALT after exactly one full cycle.
- halt_req is sampled only at the boundary; toggling it mid-cycle has no effect.
- Stall at the boundary phase takes precedence: no wrap, no count, no halt until stall drops.
- cycle_start:
  - High only on the first clock in RUN with phase 0 after IDLE, HALT or a wrap.
  - Not re-asserted while stalled in phase 0.
- alu_ena: exactly one high clock per instruction cycle, even if stall interrupts the ALU phase. The strobe is emitted on the first non-stalled clock of ALU_PHASE.
- step outside HALT is ignored.
- instr_cnt wraps from 2^CNT_W-1 to 0 with no flag.
- Reset asserted mid-cycle: all outputs clear immediately (async), regardless of state.
- Defaults match the legacy timing: alu_ena in the 2nd clock of the cycle, fetch for 4 clocks starting in the 4th.

Test Plan:
- Defaults, release reset, no stall/halt for 20 clocks -> clock 1 IDLE; phases 0..7 repeat from clock 2; alu_ena high at phase 1; fetch high at phases 3-6; cycle_start at every phase 0; instr_cnt=2 after clock 17.
- Stall held 3 clocks at phase 1 -> phase stays 1 for 4 clocks; alu_ena pulses exactly once; instr_cnt increments 3 clocks later than unstalled.
- halt_req raised at phase 4 -> phases 5,6,7 complete; halted=1 at next clock; phase=0; instr_cnt+1; fetch/alu_ena stay 0 while held.
- In HALT with halt_req=1, step pulse -> exactly 8 RUN clocks (phase 0..7), one alu_ena, one cycle_start, then halted=1; instr_cnt+1.
- Override NUM_PHASES=5, ALU_PHASE=4, FETCH_START=FETCH_END=0 -> 5-clock cycle; fetch on phase 0 only; alu_ena on phase 4; stall at phase 4 holds without wrap.
- Override CNT_W=4, run 17 cycles -> instr_cnt wraps 15->0->1; async reset mid-phase 3 -> all outputs 0 before next edge.
